// File: rtl/amm_trans_block.sv
// Avalon-MM burst master for the memory checker: each command becomes one pattern write burst or one read burst.
// Build macro TRANS_ERR_INJ_EN enables a one-shot corruption of bit 0 on the next accepted write beat.
module amm_trans_block #(
    parameter int AMM_ADDR_W  = 31,
    parameter int AMM_DATA_W  = 64,
    parameter int AMM_BURST_W = 11
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    test_start_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [AMM_ADDR_W-1:0]   cmd_addr_i,
    input  logic [AMM_BURST_W-2:0]  cmd_words_i,
    input  logic                    cmd_data_mode_i,
    input  logic [7:0]              cmd_data_ptrn_i,
    output logic [AMM_ADDR_W-1:0]   address_o,
    output logic                    read_o,
    output logic                    write_o,
    output logic [AMM_DATA_W-1:0]   writedata_o,
    output logic [AMM_BURST_W-1:0]  burstcount_o,
    output logic [AMM_DATA_W/8-1:0] byteenable_o,
    input  logic                    waitrequest_i,
    output logic                    cmp_en_o,
    output logic [AMM_ADDR_W-1:0]   cmp_start_addr_o,
    output logic [AMM_BURST_W-2:0]  cmp_words_o,
    output logic                    cmp_data_mode_o,
    output logic [7:0]              cmp_data_ptrn_o,
    output logic [31:0]             trans_cnt_o,
    output logic                    busy_o,
    input  logic                    err_inj_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    localparam logic [AMM_BURST_W-2:0] WORDS_ONE = 1;
    localparam logic [AMM_BURST_W-1:0] BC_ONE    = 1;

    state_e                 state_q, state_d;
    logic [AMM_ADDR_W-1:0]  addr_q, addr_d;
    logic [AMM_BURST_W-2:0] words_q, words_d;
    logic [AMM_BURST_W-2:0] beats_left_q, beats_left_d;
    logic [AMM_BURST_W-1:0] burstcount_q, burstcount_d;
    logic                   mode_q, mode_d;
    logic [7:0]             seed_q, seed_d;
    logic [7:0]             ptrn_q, ptrn_d;
    logic [31:0]            trans_cnt_q, trans_cnt_d;

    logic cmd_accept;
    logic wr_beat;
    logic wr_last;
    logic rd_accept;
    logic inj_flip;

    assign cmd_accept = cmd_valid_i && cmd_ready_o;
    assign wr_beat    = write_o && !waitrequest_i;
    assign wr_last    = wr_beat && (beats_left_q == '0);
    assign rd_accept  = read_o && !waitrequest_i;

    // NOTE: sequential state uses non-blocking assignments; every comb block defaults its outputs first so no latch is inferred.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (test_start_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cmd_accept) state_d = cmd_write_i ? WRITE : READ;
                WRITE:   if (wr_last)    state_d = IDLE;
                READ:    if (rd_accept)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready_o = 1'b0;
        write_o     = 1'b0;
        read_o      = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE:  cmd_ready_o = rst_i && !test_start_i;
            WRITE: begin
                write_o = 1'b1;
                busy_o  = 1'b1;
            end
            READ: begin
                read_o = 1'b1;
                busy_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Random mode steps the same 8-bit LFSR the compare block regenerates from the seed.
    always_comb begin
        addr_d       = addr_q;
        words_d      = words_q;
        beats_left_d = beats_left_q;
        burstcount_d = burstcount_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        ptrn_d       = ptrn_q;
        trans_cnt_d  = trans_cnt_q;
        if (test_start_i) begin
            trans_cnt_d = '0;
        end else begin
            if (cmd_accept) begin
                addr_d       = cmd_addr_i;
                words_d      = cmd_words_i;
                beats_left_d = cmd_words_i;
                burstcount_d = {1'b0, cmd_words_i} + BC_ONE;
                mode_d       = cmd_data_mode_i;
                seed_d       = cmd_data_ptrn_i;
                ptrn_d       = cmd_data_ptrn_i;
            end
            if (wr_beat) begin
                beats_left_d = beats_left_q - WORDS_ONE;
                if (mode_q) begin
                    ptrn_d = {ptrn_q[6:0], ptrn_q[6] ^ ptrn_q[1] ^ ptrn_q[0]};
                end
            end
            if (wr_last || rd_accept) begin
                trans_cnt_d = trans_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q       <= '0;
            words_q      <= '0;
            beats_left_q <= '0;
            burstcount_q <= '0;
            mode_q       <= 1'b0;
            seed_q       <= '0;
            ptrn_q       <= '0;
            trans_cnt_q  <= '0;
        end else begin
            addr_q       <= addr_d;
            words_q      <= words_d;
            beats_left_q <= beats_left_d;
            burstcount_q <= burstcount_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            ptrn_q       <= ptrn_d;
            trans_cnt_q  <= trans_cnt_d;
        end
    end

`ifdef TRANS_ERR_INJ_EN
    logic err_armed_q, err_armed_d;

    // The consuming beat clears the flag even if a new pulse arrives with it.
    always_comb begin
        err_armed_d = err_armed_q;
        if (test_start_i) begin
            err_armed_d = 1'b0;
        end else if (wr_beat && err_armed_q) begin
            err_armed_d = 1'b0;
        end else if (err_inj_i) begin
            err_armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_armed_q <= 1'b0;
        end else begin
            err_armed_q <= err_armed_d;
        end
    end

    assign inj_flip = err_armed_q && write_o;
`else
    logic unused_err_inj;

    assign unused_err_inj = err_inj_i;
    assign inj_flip       = 1'b0;
`endif

    always_comb begin
        writedata_o    = {(AMM_DATA_W/8){ptrn_q}};
        writedata_o[0] = ptrn_q[0] ^ inj_flip;
    end

    assign address_o        = addr_q;
    assign burstcount_o     = burstcount_q;
    assign byteenable_o     = '1;
    assign cmp_en_o         = rd_accept && !test_start_i;
    assign cmp_start_addr_o = addr_q;
    assign cmp_words_o      = words_q;
    assign cmp_data_mode_o  = mode_q;
    assign cmp_data_ptrn_o  = seed_q;
    assign trans_cnt_o      = trans_cnt_q;

endmodule
